result_display_scan: RTL and testbench

- Output-side counterpart to the keypad matrix scanner. The keypad block scans columns in and produces key codes; this block takes the calculator's 8-bit result and operator code and drives a time-multiplexed 4-digit 7-segment display.
- Converts binary to BCD sequentially using shift-add-3 (double dabble), blanks leading zeros, and scans digit enables at a programmable rate.
- Sits in calculator_top between the controller's result/op_display outputs and the board pins.

---
 rtl/result_display_scan.sv | 193 +++++++++++++++++++
 tb/tb_result_display_scan.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display_scan.sv
// Converts an 8-bit result to BCD with double dabble and scans it, together
// with an operator glyph, across a 4-digit multiplexed 7-segment display.
module result_display_scan #(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       load,
  input  logic [3:0] op_display,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d, bcd_adj;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  op_latch_q, op_latch_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_value_q, pend_value_d;
  logic [3:0]  pend_op_q, pend_op_d;
  logic        busy_q, busy_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d, op_q, op_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  digit_q, digit_d;
  logic [6:0]  seg_q, seg_d, glyph;
  logic [3:0]  an_q, an_d;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'b0111111;
      4'd1:    digit_glyph = 7'b0000110;
      4'd2:    digit_glyph = 7'b1011011;
      4'd3:    digit_glyph = 7'b1001111;
      4'd4:    digit_glyph = 7'b1100110;
      4'd5:    digit_glyph = 7'b1101101;
      4'd6:    digit_glyph = 7'b1111101;
      4'd7:    digit_glyph = 7'b0000111;
      4'd8:    digit_glyph = 7'b1111111;
      4'd9:    digit_glyph = 7'b1101111;
      default: digit_glyph = 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] op_glyph(input logic [3:0] o);
    case (o)
      4'hA:    op_glyph = 7'b1110111;
      4'hB:    op_glyph = 7'b1000000;
      4'hC:    op_glyph = 7'b1011110;
      4'hD:    op_glyph = 7'b1110110;
      default: op_glyph = 7'b0000000;
    endcase
  endfunction

  // Conversion FSM next-state: double dabble plus one-deep pending buffer.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    op_latch_d   = op_latch_q;
    pend_d       = pend_q;
    pend_value_d = pend_value_q;
    pend_op_d    = pend_op_q;
    busy_d       = busy_q;
    hund_d       = hund_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    op_d         = op_q;
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
    case (state_q)
      StIdle: begin
        if (load) begin
          shift_d    = value;
          op_latch_d = op_display;
          bcd_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StCommit;
        if (load) begin
          pend_d       = 1'b1;
          pend_value_d = value;
          pend_op_d    = op_display;
        end
      end
      StCommit: begin
        hund_d = bcd_q[11:8];
        tens_d = bcd_q[7:4];
        ones_d = bcd_q[3:0];
        op_d   = op_latch_q;
        bcd_d  = '0;
        cnt_d  = '0;
        // A load landing on the commit cycle is newer than anything pending.
        if (load) begin
          shift_d    = value;
          op_latch_d = op_display;
          pend_d     = 1'b0;
          state_d    = StShift;
        end else if (pend_q) begin
          shift_d    = pend_value_q;
          op_latch_d = pend_op_q;
          pend_d     = 1'b0;
          state_d    = StShift;
        end else begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan prescaler, digit index and registered segment/anode drive.
  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    digit_d = (presc_q == PRESC_MAX) ? digit_q + 2'd1 : digit_q;
    glyph   = 7'b0000000;
    case (digit_q)
      2'd0: glyph = digit_glyph(ones_q);
      2'd1: glyph = (BLANK_LEADING && hund_q == 4'd0 && tens_q == 4'd0) ? 7'b0000000
                                                                        : digit_glyph(tens_q);
      2'd2: glyph = (BLANK_LEADING && hund_q == 4'd0) ? 7'b0000000 : digit_glyph(hund_q);
      default: glyph = op_glyph(op_q);
    endcase
    seg_d = ACTIVE_LOW ? ~glyph : glyph;
    an_d  = ACTIVE_LOW ? ~(4'b0001 << digit_q) : (4'b0001 << digit_q);
  end

  // State registers, all synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      op_latch_q   <= '0;
      pend_q       <= 1'b0;
      pend_value_q <= '0;
      pend_op_q    <= '0;
      busy_q       <= 1'b0;
      hund_q       <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      op_q         <= '0;
      presc_q      <= '0;
      digit_q      <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      op_latch_q   <= op_latch_d;
      pend_q       <= pend_d;
      pend_value_q <= pend_value_d;
      pend_op_q    <= pend_op_d;
      busy_q       <= busy_d;
      hund_q       <= hund_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      op_q         <= op_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_result_display_scan.sv
// Bench for result_display_scan: scan order, latency, pending loads, reset abort, glyphs.
module tb_result_display_scan;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic       load;
  logic [3:0] op_display;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] op;
  } exp_t;
  exp_t sb[$];

  result_display_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .ACTIVE_LOW   (1'b1),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .op_display(op_display),
    .seg       (seg),
    .an        (an),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] dig_ah(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] op_ah(input logic [3:0] o);
    case (o)
      4'hA: return 7'b1110111;
      4'hB: return 7'b1000000;
      4'hC: return 7'b1011110;
      4'hD: return 7'b1110110;
      default: return 7'b0000000;
    endcase
  endfunction

  // Expected active-low segment pattern for digit position idx.
  function automatic logic [6:0] exp_seg(input exp_t e, input int idx);
    int h, t, o;
    logic [6:0] g;
    h = int'(e.v) / 100;
    t = (int'(e.v) / 10) % 10;
    o = int'(e.v) % 10;
    case (idx)
      0: g = dig_ah(o);
      1: g = (h == 0 && t == 0) ? 7'b0000000 : dig_ah(t);
      2: g = (h == 0) ? 7'b0000000 : dig_ah(h);
      default: g = op_ah(e.op);
    endcase
    return ~g;
  endfunction

  function automatic int an_index(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v, input logic [3:0] op, input bit overwrite);
    exp_t e;
    e.v = v;
    e.op = op;
    if (overwrite && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(e);
    load = 1'b1;
    value = v;
    op_display = op;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) check("busy_timeout", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Capture one full scan and compare all four digit positions.
  task automatic check_display(input exp_t e, input string tag);
    logic [6:0] cap[4];
    int idx;
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    repeat (2) @(negedge clk);
    repeat (4 * SCAN_DIV + 4) begin
      @(negedge clk);
      idx = an_index(an);
      if (idx >= 0) cap[idx] = seg;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_d%0d", tag, i), {25'd0, cap[i]}, {25'd0, exp_seg(e, i)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [7:0] v, input logic [3:0] op, input string tag);
    exp_t e;
    do_load(v, op, 1'b0);
    wait_idle();
    pop_exp(e);
    check_display(e, tag);
  endtask

  initial begin
    exp_t e;
    exp_t zero_e;
    bit found;
    int idx;
    zero_e = '0;
    reset = 1'b1;
    load = 1'b0;
    value = '0;
    op_display = '0;

    // Reset levels.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Scan order and dwell after reset.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110) found = 1;
    end
    check("scan_start", {31'd0, found}, 32'd1);
    check("scan_seg0", {25'd0, seg}, 32'h40);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("scan_an%0d", i), {28'd0, an}, {28'd0, ~(4'b0001 << (i / 4))});
    end
    @(posedge clk);
    #1;

    // 255 with 'A': busy window then full display.
    do_load(8'd255, 4'hA, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("busy_n%0d", k), {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("busy_n10", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    pop_exp(e);
    check_display(e, "v255");

    // Leading-zero blanking.
    run_one(8'd7, 4'hF, "v7");
    run_one(8'd105, 4'hB, "v105");

    // Pending overwrite: 42, 199 (overwritten), 0.
    do_load(8'd42, 4'hC, 1'b0);
    tick();
    tick();
    do_load(8'd199, 4'hD, 1'b0);
    tick();
    do_load(8'd0, 4'hD, 1'b1);
    repeat (6) tick();
    pop_exp(e);
    @(negedge clk);
    check("pend_busy12", {31'd0, busy}, 32'd1);
    idx = an_index(an);
    if (idx < 0) check("pend_an", {28'd0, an}, 32'hE);
    else check("pend_seg42", {25'd0, seg}, {25'd0, exp_seg(e, idx)});
    @(posedge clk);
    #1;
    repeat (5) tick();
    @(negedge clk);
    check("pend_busy18", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pend_busy19", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    pop_exp(e);
    check_display(e, "pend0");

    // Reset aborts conversion of 88.
    do_load(8'd88, 4'hA, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_display(zero_e, "abort");
    repeat (20) tick();
    check("abort_busy_late", {31'd0, busy}, 32'd0);
    check_display(zero_e, "abort_late");

    // All ten digit glyphs with a blank operator.
    for (int d = 0; d < 10; d++) begin
      run_one(8'(d), 4'hF, $sformatf("glyph%0d", d));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
